// File: rtl/alu.sv
// Y-86 execute-stage ALU: ADD/SUB/AND/XOR on two operands with registered
// result, carry and ZF/SF/OF condition flags (one cycle of latency).
module alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       cond,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zf,
    output logic             sf,
    output logic             of
    ,
    output logic             out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [WIDTH-1:0] b_op_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             of_s;

    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             zf_r;
    logic             sf_r;
    logic             of_r;
    logic             out_valid_r;

    // Adder operand select: SUB reuses the adder as a + ~b + 1.
    always_comb begin
        b_op_s = b;
        cin_s  = 1'b0;
        case (cond)
            OP_SUB: begin
                b_op_s = ~b;
                cin_s  = 1'b1;
            end
            default: begin
                b_op_s = b;
                cin_s  = 1'b0;
            end
        endcase
    end

    assign sum_s = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};

    // Result/flag selection; overflow when adder inputs agree in sign but the sum differs.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        of_s    = 1'b0;
        case (cond)
            OP_ADD, OP_SUB: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                of_s    = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin
                res_s   = a & b;
                carry_s = 1'b0;
                of_s    = 1'b0;
            end
            OP_XOR: begin
                res_s   = a ^ b;
                carry_s = 1'b0;
                of_s    = 1'b0;
            end
            default: begin
                res_s   = {WIDTH{1'b0}};
                carry_s = 1'b0;
                of_s    = 1'b0;
            end
        endcase
    end

    // Output stage: capture on accepted operations, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zf_r        <= 1'b0;
            sf_r        <= 1'b0;
            of_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                result_r <= res_s;
                carry_r  <= carry_s;
                zf_r     <= (res_s == {WIDTH{1'b0}});
                sf_r     <= res_s[WIDTH-1];
                of_r     <= of_s;
            end
        end
    end

    assign result    = result_r;
    assign carry     = carry_r;
    assign zf        = zf_r;
    assign sf        = sf_r;
    assign of        = of_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected outputs are queued when stimulus is
// driven and compared one clock later on the falling edge.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  cond;
    logic        in_valid;
    logic [63:0] result;
    logic        carry;
    logic        zf;
    logic        sf;
    logic        of;
    logic        out_valid;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        c;
        logic        z;
        logic        s;
        logic        o;
        logic        v;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   checks;
    int   failures;

    alu #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cond(cond), .in_valid(in_valid),
        .result(result), .carry(carry), .zf(zf), .sf(sf), .of(of), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent reference: widened signed/unsigned arithmetic.
    function automatic exp_t model(input string tag, input logic [63:0] ma,
                                   input logic [63:0] mb, input logic [1:0] mc);
        exp_t        e;
        logic [64:0] us;
        logic [65:0] ss;
        e.tag = tag;
        e.c = 1'b0;
        e.o = 1'b0;
        e.v = 1'b1;
        case (mc)
            2'b00: begin
                us = {1'b0, ma} + {1'b0, mb};
                ss = {{2{ma[63]}}, ma} + {{2{mb[63]}}, mb};
                e.res = us[63:0];
                e.c = us[64];
                e.o = (ss[64] != ss[63]);
            end
            2'b01: begin
                ss = {{2{ma[63]}}, ma} - {{2{mb[63]}}, mb};
                e.res = ma - mb;
                e.c = (ma >= mb);
                e.o = (ss[64] != ss[63]);
            end
            2'b10: e.res = ma & mb;
            default: e.res = ma ^ mb;
        endcase
        e.z = (e.res == 64'd0);
        e.s = e.res[63];
        return e;
    endfunction

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".result"}, result, e.res);
            check({e.tag, ".carry"}, {63'd0, carry}, {63'd0, e.c});
            check({e.tag, ".zf"}, {63'd0, zf}, {63'd0, e.z});
            check({e.tag, ".sf"}, {63'd0, sf}, {63'd0, e.s});
            check({e.tag, ".of"}, {63'd0, of}, {63'd0, e.o});
            check({e.tag, ".valid"}, {63'd0, out_valid}, {63'd0, e.v});
        end
    endtask

    // One cycle: compare last cycle's prediction, drive new inputs, push prediction.
    task automatic step(input string tag, input logic va, input logic [63:0] sa,
                        input logic [63:0] sbv, input logic [1:0] sc);
        exp_t e;
        @(negedge clk);
        compare_front();
        a = sa;
        b = sbv;
        cond = sc;
        in_valid = va;
        if (va) begin
            e = model(tag, sa, sbv, sc);
        end else begin
            e = last_e;
            e.tag = tag;
            e.v = 1'b0;
        end
        last_e = e;
        sb_q.push_back(e);
    endtask

    // Directed vector with spelled-out expectations.
    task automatic step_exp(input string tag, input logic [63:0] sa, input logic [63:0] sbv,
                            input logic [1:0] sc, input logic [63:0] r, input logic ec,
                            input logic ez, input logic es, input logic eo);
        exp_t e;
        @(negedge clk);
        compare_front();
        a = sa;
        b = sbv;
        cond = sc;
        in_valid = 1'b1;
        e.tag = tag; e.res = r; e.c = ec; e.z = ez; e.s = es; e.o = eo; e.v = 1'b1;
        last_e = e;
        sb_q.push_back(e);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        a = 64'd0;
        b = 64'd0;
        cond = 2'b00;
        last_e = '{tag: "rst", res: 64'd0, c: 1'b0, z: 1'b0, s: 1'b0, o: 1'b0, v: 1'b0};
        #12;
        check("rst.result", result, 64'd0);
        check("rst.zf", {63'd0, zf}, 64'd0);
        check("rst.valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        step_exp("xor1", 64'h2, 64'h00000000FFFFFFFF, 2'b11, 64'h00000000FFFFFFFD, 1'b0, 1'b0, 1'b0, 1'b0);
        step_exp("sub1", 64'hABF4AAAF, 64'h803FFC00, 2'b01, 64'h2BB4AEAF, 1'b1, 1'b0, 1'b0, 1'b0);
        step_exp("and1", 64'h2F049181, 64'h4070C471, 2'b10, 64'h00008001, 1'b0, 1'b0, 1'b0, 1'b0);
        step_exp("xor2", 64'h80000062, 64'h33FE3783, 2'b11, 64'hB3FE37E1, 1'b0, 1'b0, 1'b0, 1'b0);
        step_exp("addov", 64'h7FFFFFFFFFFFFFFF, 64'd1, 2'b00, 64'h8000000000000000, 1'b0, 1'b0, 1'b1, 1'b1);
        step_exp("addz", 64'hFFFFFFFFFFFFFFFF, 64'd1, 2'b00, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step_exp("subov", 64'h8000000000000000, 64'd1, 2'b01, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        step_exp("subneg", 64'd0, 64'd1, 2'b01, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        // Hold: in_valid low with changing operands.
        step("hold1", 1'b0, 64'h1234, 64'h5678, 2'b00);
        step("hold2", 1'b0, 64'hDEAD, 64'hBEEF, 2'b11);

        for (int i = 0; i < 24; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-stream, with an operation in flight.
        step("pre_rst", 1'b1, 64'h7, 64'h9, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check("arst.result", result, 64'd0);
        check("arst.carry", {63'd0, carry}, 64'd0);
        check("arst.zf", {63'd0, zf}, 64'd0);
        check("arst.sf", {63'd0, sf}, 64'd0);
        check("arst.of", {63'd0, of}, 64'd0);
        check("arst.valid", {63'd0, out_valid}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        last_e = '{tag: "post_rst", res: 64'd0, c: 1'b0, z: 1'b0, s: 1'b0, o: 1'b0, v: 1'b0};
        sb_q.push_back(last_e);

        step("after_rst", 1'b1, 64'd5, 64'd5, 2'b01);
        step("drain", 1'b0, 64'd0, 64'd0, 2'b00);
        @(negedge clk);
        compare_front();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
